// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
// Measures the period and high time of an asynchronous square wave
// (typically a divided clock) in units of clock_in cycles. After every
// complete cycle of signal_in it presents the result for one cycle with a
// valid strobe. A missing rising edge within 2^WIDTH-1 cycles raises a
// sticky overflow flag. The flag stays set until the next completed
// measurement.
//
// Ports:
//   clock_in   system clock; all logic uses its rising edge
//   reset      synchronous, active-high reset
//   signal_in  measured signal, asynchronous to clock_in
//   period     clock_in cycles between the last two rising edges
//   high_time  clock_in cycles signal_in was high within that period
//   valid      one-cycle strobe; period/high_time updated on this edge
//   overflow   sticky; no rising edge arrived within 2^WIDTH-1 cycles
// ---------------------------------------------------------------------------
module period_meter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             signal_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    // Last counter value before a measurement can no longer fit: 2^WIDTH-2
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    // Synchroniser chain and edge history
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Measurement state
    logic [0:0]             state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic                   fall_seen_q, fall_seen_d;
    logic [WIDTH-1:0]       hts_q, hts_d;

    // Registered outputs
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;

    // Edge detection on the synchronised signal
    logic sync_s;
    logic rise;
    logic fall;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_q;
    assign fall   = ~sync_s & prev_q;

    // State register
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q      <= '0;
            prev_q      <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fall_seen_q <= 1'b0;
            hts_q       <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fall_seen_q <= fall_seen_d;
            hts_q       <= hts_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], signal_in};
        prev_d      = sync_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        fall_seen_d = fall_seen_q;
        hts_d       = hts_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                // First rising edge only arms the counter; nothing to report
                if (rise) begin
                    state_d     = ST_MEASURE;
                    cnt_d       = '0;
                    fall_seen_d = 1'b0;
                end
            end

            ST_MEASURE: begin
                if (rise) begin
                    // A rise without a preceding fall is treated as a restart
                    cnt_d       = '0;
                    fall_seen_d = 1'b0;
                    if (fall_seen_q) begin
                        period_d    = cnt_q + WIDTH'(1);
                        high_time_d = hts_q;
                        valid_d     = 1'b1;
                        overflow_d  = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Next cycle would need a period that does not fit
                    state_d    = ST_IDLE;
                    overflow_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (fall) begin
                        hts_d       = cnt_q + WIDTH'(1);
                        fall_seen_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_period_meter.sv
// ---------------------------------------------------------------------------
// tb_period_meter
// Scoreboard bench: the stimulus pushes the hand-computed result (period,
// high time, cycle at which valid must appear) at each rising edge it
// drives. An independent monitor pops and compares on every valid strobe.
// ---------------------------------------------------------------------------
module tb_period_meter;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] h;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             sig;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             overflow;

    int   checks;
    int   errors;
    int   cyc;
    logic prev_valid;
    exp_t q[$];

    period_meter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clock_in  (clk),
        .reset     (reset),
        .signal_in (sig),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rise driven now: valid is due three clock_in edges later
    task automatic push_exp(input int p, input int h);
        exp_t e;
        e.p   = WIDTH'(p);
        e.h   = WIDTH'(h);
        e.cyc = cyc + 3;
        q.push_back(e);
    endtask

    // n periods of h high / l low; the first rise optionally completes the
    // previous segment's period (fp, fh), later rises complete (h+l, h)
    task automatic wave(input int h, input int l, input int n,
                        input bit first_en, input int fp, input int fh);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                if (first_en) push_exp(fp, fh);
            end else begin
                push_exp(h + l, h);
            end
            sig = 1'b1;
            step(h);
            sig = 1'b0;
            step(l);
        end
    endtask

    task automatic chk_outputs(input string tag, input int p, input int h,
                               input int v, input int o);
        chk({tag, "_period"},    32'(period),    32'(p));
        chk({tag, "_high_time"}, 32'(high_time), 32'(h));
        chk({tag, "_valid"},     32'(valid),     32'(v));
        chk({tag, "_overflow"},  32'(overflow),  32'(o));
    endtask

    // Monitor: compare every valid strobe against the scoreboard
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            chk("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("period",          32'(period),    32'(e.p));
                chk("high_time",       32'(high_time), 32'(e.h));
                chk("valid_cycle",     32'(cyc),       32'(e.cyc));
                chk("overflow_at_val", 32'(overflow),  32'd0);
            end
        end
        prev_valid <= valid;
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sig    = 1'b0;
        step(3);
        chk_outputs("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Idle input: nothing moves
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_valid",    32'(valid),    32'd0);
            chk("idle_overflow", 32'(overflow), 32'd0);
        end
        chk_outputs("idle_end", 0, 0, 0, 0);

        // 3 high / 5 low from IDLE: first rise only arms
        wave(3, 5, 4, 1'b0, 0, 0);

        // Fastest input; its first rise closes the last 3/5 period
        wave(1, 1, 6, 1'b1, 8, 3);

        // Stuck high: first rise closes the last 1/1 period, then timeout
        push_exp(2, 1);
        sig = 1'b1;
        step(300);
        chk_outputs("stuck", 2, 1, 0, 1);

        // Recovery with 10/10; overflow holds until the first valid
        sig = 1'b0;
        step(10);
        chk("stuck_low_overflow", 32'(overflow), 32'd1);
        sig = 1'b1;
        step(10);
        chk("armed_overflow", 32'(overflow), 32'd1);
        sig = 1'b0;
        step(10);
        wave(10, 10, 3, 1'b1, 20, 10);
        chk("recovered_overflow", 32'(overflow), 32'd0);

        // 255-cycle periods: each rise lands exactly at the timeout count
        wave(100, 155, 3, 1'b1, 20, 10);
        chk("max_period_overflow", 32'(overflow), 32'd0);

        // 4/4 with a reset pulse during a low phase
        wave(4, 4, 3, 1'b1, 255, 100);
        push_exp(8, 4);
        sig = 1'b1;
        step(4);
        sig = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        chk_outputs("mid_reset", 0, 0, 0, 0);
        reset = 1'b0;
        step(2);
        wave(4, 4, 3, 1'b0, 0, 0);
        chk_outputs("after_reset", 8, 4, 0, 0);

        step(20);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
